// File: rtl/gsim.sv
// Gauss-Seidel solver for the fixed 16x16 banded system A*x = b.
// Row i of A is 20 on the diagonal, -13 at distance 1, 6 at distance 2 and
// -1 at distance 3. The block collects 16 integer b values, runs ITER full
// sweeps with one row update per cycle, and then streams the 16 Q16.16
// results out on consecutive cycles.
module gsim #(
    parameter int ITER = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [15:0] b_in,
    output logic        out_valid,
    output logic [31:0] x_out
);

    localparam int SW = (ITER < 2) ? 1 : $clog2(ITER + 1);

    // floor(n/5) == (n * RECIP5) >> 38 exactly for every n < 2^38.
    localparam logic [35:0] RECIP5 = 36'd54975581389;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        OUT
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [15:0]   b_reg [16];
    logic [31:0]   x_reg [16];
    logic [3:0]    load_cnt_reg;
    logic [3:0]    row_reg;
    logic [SW-1:0] sweep_reg;
    logic [4:0]    out_cnt_reg;
    logic          out_valid_reg;
    logic [31:0]   x_out_reg;

    logic load_en;
    logic frame_start;
    logic calc_en;
    logic calc_done;

    assign load_en     = ((state_reg == IDLE) || (state_reg == LOAD)) && in_en;
    assign frame_start = load_en && (load_cnt_reg == 4'd15);
    assign calc_en     = (state_reg == CALC);
    assign calc_done   = calc_en && (row_reg == 4'd15) && (sweep_reg == SW'(ITER - 1));

    // ------------------------------------------------------------------
    // Row update datapath
    // ------------------------------------------------------------------

    // pair_sum[d] = x[i-d] + x[i+d], neighbours outside 0..15 read as zero
    logic [3:1][41:0] pair_sum;

    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_nb
            logic [31:0] lo_val;
            logic [31:0] hi_val;
            assign lo_val = (row_reg >= 4'(gi))      ? x_reg[row_reg - 4'(gi)] : 32'h0;
            assign hi_val = (row_reg <= 4'(15 - gi)) ? x_reg[row_reg + 4'(gi)] : 32'h0;
            assign pair_sum[gi] = {{10{lo_val[31]}}, lo_val} + {{10{hi_val[31]}}, hi_val};
        end
    endgenerate

    logic signed [41:0] p1;
    logic signed [41:0] p2;
    logic signed [41:0] p3;
    logic        [15:0] b_cur;
    logic signed [41:0] b_ext;
    logic signed [41:0] sum_full;
    logic               neg;
    logic        [41:0] mag;
    logic        [41:0] rnd;
    logic        [39:0] quarter;
    logic        [79:0] prod;
    logic        [41:0] q;
    logic        [31:0] x_new;

    assign p1    = $signed(pair_sum[1]);
    assign p2    = $signed(pair_sum[2]);
    assign p3    = $signed(pair_sum[3]);
    assign b_cur = b_reg[row_reg];
    assign b_ext = {{10{b_cur[15]}}, b_cur, 16'h0000};

    // Numerator is bounded by about 2^37, so 42 bits never overflow.
    assign sum_full = b_ext + p1 * 42'sd13 - p2 * 42'sd6 + p3;

    // Round half away from zero: q = floor((|s| + 10) / 20) = floor(floor((|s|+10)/4) / 5)
    assign neg     = sum_full[41];
    assign mag     = neg ? 42'(-sum_full) : 42'(sum_full);
    assign rnd     = mag + 42'd10;
    assign quarter = 40'(rnd >> 2);
    assign prod    = 80'(quarter) * 80'(RECIP5);
    assign q       = 42'(prod >> 38);

    // Restore the sign and clamp to the 32-bit signed range
    always_comb begin
        x_new = 32'h0;
        if (!neg) begin
            x_new = (q > 42'd2147483647) ? 32'h7FFF_FFFF : q[31:0];
        end else begin
            x_new = (q > 42'd2147483648) ? 32'h8000_0000 : (32'h0 - q[31:0]);
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_en)                     state_next = LOAD;
            LOAD: if (frame_start)               state_next = CALC;
            CALC: if (calc_done)                 state_next = OUT;
            OUT:  if (out_cnt_reg == 5'd16)      state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // Input word counter, wraps back to 0 after the 16th word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt_reg <= 4'd0;
        end else if (load_en) begin
            load_cnt_reg <= load_cnt_reg + 4'd1;
        end
    end

    // Row and sweep counters for the solve phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_reg   <= 4'd0;
            sweep_reg <= '0;
        end else if (frame_start) begin
            row_reg   <= 4'd0;
            sweep_reg <= '0;
        end else if (calc_en) begin
            row_reg <= row_reg + 4'd1;
            if (row_reg == 4'd15) begin
                sweep_reg <= sweep_reg + SW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------

    generate
        for (gi = 0; gi < 16; gi++) begin : g_store
            // b element gi captured in arrival order
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    b_reg[gi] <= 16'h0;
                end else if (load_en && (load_cnt_reg == 4'(gi))) begin
                    b_reg[gi] <= b_in;
                end
            end

            // x element gi: zeroed at frame start, rewritten when its row comes up
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    x_reg[gi] <= 32'h0;
                end else if (frame_start) begin
                    x_reg[gi] <= 32'h0;
                end else if (calc_en && (row_reg == 4'(gi))) begin
                    x_reg[gi] <= x_new;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stream
    // ------------------------------------------------------------------

    // Emit x[0..15] on 16 consecutive cycles, then drop the strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            x_out_reg     <= 32'h0;
            out_cnt_reg   <= 5'd0;
        end else if ((state_reg == OUT) && !out_cnt_reg[4]) begin
            out_valid_reg <= 1'b1;
            x_out_reg     <= x_reg[out_cnt_reg[3:0]];
            out_cnt_reg   <= out_cnt_reg + 5'd1;
        end else begin
            out_valid_reg <= 1'b0;
            x_out_reg     <= 32'h0;
            out_cnt_reg   <= 5'd0;
        end
    end

    assign out_valid = out_valid_reg;
    assign x_out     = x_out_reg;

endmodule

// File: tb/tb_gsim.sv
// Directed testbench for gsim: zero vector, all-ones solution, the reference
// vector, reset during the solve, back-to-back frames and in_en noise.
module tb_gsim;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        in_en = 1'b0;
    logic [15:0] b_in  = 16'h0;
    logic        out_valid;
    logic [31:0] x_out;

    gsim #(.ITER(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .b_in      (b_in),
        .out_valid (out_valid),
        .x_out     (x_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        longint d;
        n_checks++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d <= tol) begin
            n_pass++;
            $display("check %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int a_coef(input int i, input int j);
        int d;
        d = (i > j) ? i - j : j - i;
        case (d)
            0:       return 20;
            1:       return -13;
            2:       return 6;
            3:       return -1;
            default: return 0;
        endcase
    endfunction

    real xs[16] = '{402.1120, 1689.5337, 2455.4774, 563.1671, 703.0137, 1745.1919, 33.2002, 607.1379,
                    -477.5896, 869.0944, 1907.5238, 1524.3409, 596.4155, 1476.6346, 1011.5708, -1330.8986};
    int  b_ones[16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    int  b_spec[16];
    int  x_spec[16];
    int  bv[16];
    int  got_x[16];
    int  lat;

    // Stream bv[] in; with gap=1 an idle cycle follows some words
    task automatic send_frame(input int gap);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            in_en = 1'b1;
            b_in  = 16'(bv[k]);
            if (gap != 0 && (k % 3) == 1) begin
                @(negedge clk);
                in_en = 1'b0;
                b_in  = 16'hDEAD;
            end
        end
        @(negedge clk);
        in_en = 1'b0;
        b_in  = 16'h0;
    endtask

    // Wait for the output burst, measure latency, gather the 16 words
    task automatic collect(input string tag, input int junk);
        int nvalid;
        lat = 0;
        while (!out_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
            if (junk != 0 && lat < 1500) begin
                in_en = 1'b1;
                b_in  = 16'($urandom);
            end else begin
                in_en = 1'b0;
                b_in  = 16'h0;
            end
        end
        in_en = 1'b0;
        check({tag, "_latency"}, lat, 1601, 0);
        got_x[0] = $signed(x_out);
        nvalid = out_valid ? 1 : 0;
        for (int j = 1; j < 16; j++) begin
            @(posedge clk);
            #1;
            got_x[j] = $signed(x_out);
            if (out_valid) nvalid++;
        end
        check({tag, "_valid_cycles"}, nvalid, 16, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid_after"}, out_valid, 0, 0);
        check({tag, "_xout_after"}, x_out, 0, 0);
    endtask

    task automatic check_ones(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_x%0d", tag, i), got_x[i], 65536, 2);
        end
    endtask

    task automatic check_spec(input string tag);
        real r;
        real resid;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_x%0d", tag, i), got_x[i], x_spec[i], 7);
        end
        resid = 0.0;
        for (int i = 0; i < 16; i++) begin
            r = -real'(b_spec[i]);
            for (int j = 0; j < 16; j++) begin
                r += real'(a_coef(i, j)) * real'(got_x[j]) / 65536.0;
            end
            resid += r * r;
        end
        if (resid > 1.0) resid = 1.0;
        check({tag, "_resid_e12"}, longint'(resid * 1.0e12), 0, 999999);
    endtask

    initial begin
        int spurious;
        real acc;

        // Reference b = A * x_ref rounded to the integers it came from
        for (int i = 0; i < 16; i++) begin
            acc = 0.0;
            for (int j = 0; j < 16; j++) acc += real'(a_coef(i, j)) * xs[j];
            b_spec[i] = $rtoi(acc >= 0.0 ? acc + 0.5 : acc - 0.5);
            acc = xs[i] * 65536.0;
            x_spec[i] = $rtoi(acc >= 0.0 ? acc + 0.5 : acc - 0.5);
        end

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("reset_valid", out_valid, 0, 0);
        check("reset_xout", x_out, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // All-zero b gives all-zero x
        for (int i = 0; i < 16; i++) bv[i] = 0;
        send_frame(0);
        collect("zero", 0);
        for (int i = 0; i < 16; i++) check($sformatf("zero_x%0d", i), got_x[i], 0, 0);

        // b = A * ones gives x = 1.0
        for (int i = 0; i < 16; i++) bv[i] = b_ones[i];
        send_frame(0);
        collect("ones", 0);
        check_ones("ones");

        // Reference vector, with in_en noise during the solve
        for (int i = 0; i < 16; i++) bv[i] = b_spec[i];
        send_frame(0);
        collect("spec", 1);
        check_spec("spec");

        // Reset in the middle of CALC aborts the frame silently
        send_frame(0);
        repeat (500) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        spurious = 0;
        repeat (2000) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
        end
        check("midrst_spurious", spurious, 0, 0);
        for (int i = 0; i < 16; i++) bv[i] = b_ones[i];
        send_frame(0);
        collect("after_rst", 0);
        check_ones("after_rst");

        // Two frames back to back, the second one gapped
        for (int i = 0; i < 16; i++) bv[i] = b_spec[i];
        send_frame(0);
        collect("b2b1", 0);
        check_spec("b2b1");
        for (int i = 0; i < 16; i++) bv[i] = b_ones[i];
        send_frame(1);
        collect("b2b2", 0);
        check_ones("b2b2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
